// File: rtl/board_xfer_scheduler_pkg.sv
// Shared constants for the board transfer scheduler: board count, board_sel
// encoding and the FSM state encoding.
package board_xfer_scheduler_pkg;

  localparam int unsigned NUM_BOARDS  = 8;
  localparam int unsigned BOARD_SEL_W = 4;
  localparam logic [BOARD_SEL_W-1:0] BOARD_SEL_INVALID = 4'd8;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_ARB  = 2'd1;
  localparam logic [STATE_W-1:0] ST_XFER = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/board_xfer_scheduler_rr_pick.sv
// Round-robin picker: rotates req so the board after last_idx sits at bit 0,
// isolates the lowest set bit, then maps that position back to a board index.
module rr_pick #(
  parameter int unsigned NUM_BOARDS = board_xfer_scheduler_pkg::NUM_BOARDS,
  parameter int unsigned IDX_W      = $clog2(NUM_BOARDS)
) (
  input  logic [NUM_BOARDS-1:0] req,
  input  logic [IDX_W-1:0]      last_idx,
  output logic [NUM_BOARDS-1:0] onehot_c,
  output logic [IDX_W-1:0]      idx_c,
  output logic                  found_c
);
  import board_xfer_scheduler_pkg::*;

  logic [IDX_W-1:0]      start;
  logic [NUM_BOARDS-1:0] rot;
  logic [NUM_BOARDS-1:0] low;

  always_comb begin
    start = (last_idx >= IDX_W'(NUM_BOARDS - 1)) ? '0 : last_idx + IDX_W'(1);
    rot   = '0;
    for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
      rot[IDX_W'(i)] = req[IDX_W'((i + 32'(start)) % NUM_BOARDS)];
    end
    // two's-complement trick keeps only the lowest set bit
    low      = rot & (~rot + NUM_BOARDS'(1));
    idx_c    = '0;
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
      if (low[IDX_W'(i)]) begin
        idx_c = IDX_W'((i + 32'(start)) % NUM_BOARDS);
      end
    end
    onehot_c[idx_c] = |low;
    found_c         = |req;
  end

endmodule

// File: rtl/board_xfer_scheduler.sv
// Round-robin burst scheduler: grants one board at a time for a committed
// burst of req_len beats, with a stall timeout that aborts a hung burst.
module board_xfer_scheduler #(
  parameter int unsigned NUM_BOARDS = board_xfer_scheduler_pkg::NUM_BOARDS,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_BOARDS-1:0]       req,
  input  logic [NUM_BOARDS*LEN_W-1:0] req_len,
  input  logic                        beat_valid,
  input  logic                        beat_ready,
  output logic [NUM_BOARDS-1:0]       grant,
  output logic [3:0]                  board_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);
  import board_xfer_scheduler_pkg::*;

  localparam int unsigned IDX_W   = $clog2(NUM_BOARDS);
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0]     state, state_nxt;
  logic [LEN_W-1:0]       len_q, len_nxt;
  logic [LEN_W-1:0]       beat_cnt, beat_nxt;
  logic [STALL_W-1:0]     stall_cnt, stall_nxt;
  logic [IDX_W-1:0]       win_idx, win_nxt;
  logic [IDX_W-1:0]       last_idx, last_nxt;
  logic [NUM_BOARDS-1:0]  grant_nxt;
  logic [BOARD_SEL_W-1:0] sel_nxt;
  logic                   busy_nxt, done_nxt, tmo_nxt;

  logic [NUM_BOARDS-1:0]  pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [LEN_W-1:0]       pick_len;
  logic                   accept;

  rr_pick #(
    .NUM_BOARDS (NUM_BOARDS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_idx),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx),
    .found_c  (pick_found)
  );

  // next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    beat_nxt  = beat_cnt;
    stall_nxt = stall_cnt;
    win_nxt   = win_idx;
    last_nxt  = last_idx;
    grant_nxt = '0;
    sel_nxt   = BOARD_SEL_INVALID;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    accept    = (state == ST_XFER) && beat_valid && beat_ready;
    pick_len  = '0;
    for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
      if (pick_idx == IDX_W'(i)) pick_len = req_len[i*LEN_W +: LEN_W];
    end

    case (state)
      ST_IDLE: begin
        if (enable && |req) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        beat_nxt  = '0;
        stall_nxt = '0;
        if (!pick_found) begin
          state_nxt = ST_IDLE;
        end else begin
          win_nxt = pick_idx;
          len_nxt = pick_len;
          if (pick_len == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_XFER;
            grant_nxt = pick_onehot;
            sel_nxt   = BOARD_SEL_W'(pick_idx);
          end
        end
      end
      ST_XFER: begin
        if (accept) begin
          stall_nxt = '0;
          // the final beat leaves beat_cnt alone so a full-scale length never wraps
          if (beat_cnt == len_q - LEN_W'(1)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            beat_nxt  = beat_cnt + LEN_W'(1);
            grant_nxt = grant;
            sel_nxt   = board_sel;
          end
        end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
          state_nxt = ST_IDLE;
          tmo_nxt   = 1'b1;
          last_nxt  = win_idx;
        end else begin
          stall_nxt = stall_cnt + STALL_W'(1);
          grant_nxt = grant;
          sel_nxt   = board_sel;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        last_nxt  = win_idx;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      win_idx     <= '0;
      last_idx    <= IDX_W'(NUM_BOARDS - 1);
      grant       <= '0;
      board_sel   <= BOARD_SEL_INVALID;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      beat_cnt    <= beat_nxt;
      stall_cnt   <= stall_nxt;
      win_idx     <= win_nxt;
      last_idx    <= last_nxt;
      grant       <= grant_nxt;
      board_sel   <= sel_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timeout_err <= tmo_nxt;
    end
  end

endmodule
